// File: rtl/reg_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : reg_bus_arbiter
// Description : Two-master arbiter for the shared register bus. Serialises
//               single-word read/write transactions (req/ack handshake) with
//               round-robin or fixed-priority grant, one access in flight.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_bus_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdat,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdat,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdat,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdat,

    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdat,
    input  logic [DATA_W-1:0] rdat,

    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q,   gnt_d;
    logic                we_q,    we_d;
    logic                we_l_q,  we_l_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdat_q,  wdat_d;
    logic [DATA_W-1:0]   rdat0_q, rdat0_d;
    logic [DATA_W-1:0]   rdat1_q, rdat1_d;

    logic                w_winner;

    // Pick the master to serve: a lone requester wins outright; on a tie
    // master 0 wins in fixed-priority mode, otherwise the one not granted last.
    always_comb begin
        w_winner = m1_req;
        if (m0_req && m1_req) begin
            if (FIXED_PRIO != 0) begin
                w_winner = 1'b0;
            end else begin
                w_winner = ~gnt_q;
            end
        end
    end

    // Next-state and datapath: latch the winner's command on grant, strobe
    // for one ACCESS cycle, capture read data at its end, then ack.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = 1'b0;
        we_l_d  = we_l_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat0_d = rdat0_q;
        rdat1_d = rdat1_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d   = w_winner;
                    we_l_d  = w_winner ? m1_we   : m0_we;
                    addr_d  = w_winner ? m1_addr : m0_addr;
                    wdat_d  = w_winner ? m1_wdat : m0_wdat;
                    we_d    = we_l_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_l_q) begin
                    if (gnt_q) begin
                        rdat1_d = rdat;
                    end else begin
                        rdat0_d = rdat;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            we_q    <= 1'b0;
            we_l_q  <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            we_l_q  <= we_l_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
        end
    end

    assign m0_ack  = (state_q == ACK) && !gnt_q;
    assign m1_ack  = (state_q == ACK) &&  gnt_q;
    assign m0_rdat = rdat0_q;
    assign m1_rdat = rdat1_q;
    assign we      = we_q;
    assign addr    = addr_q;
    assign wdat    = wdat_q;
    assign busy    = (state_q != IDLE);
    assign gnt     = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_reg_bus_arbiter
// Description : Self-checking bench for reg_bus_arbiter: directed vector table,
//               contention/abort sequences and a randomized two-master run
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_reg_bus_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Round-robin DUT
    logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [AW-1:0] m0_addr, m1_addr, addr;
    logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, wdat, rdat;
    logic          we, busy, gnt;

    // Fixed-priority DUT
    logic          f_m0_req, f_m1_req, f_m0_ack, f_m1_ack;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_m0_rdat, f_m1_rdat, f_wdat, f_rdat;
    logic          f_we, f_busy, f_gnt;

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdat(m0_wdat),
        .m0_ack(m0_ack), .m0_rdat(m0_rdat),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdat(m1_wdat),
        .m1_ack(m1_ack), .m1_rdat(m1_rdat),
        .we(we), .addr(addr), .wdat(wdat), .rdat(rdat),
        .busy(busy), .gnt(gnt)
    );

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(7'h10), .m0_wdat(32'h0),
        .m0_ack(f_m0_ack), .m0_rdat(f_m0_rdat),
        .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(7'h11), .m1_wdat(32'h0),
        .m1_ack(f_m1_ack), .m1_rdat(f_m1_rdat),
        .we(f_we), .addr(f_addr), .wdat(f_wdat), .rdat(f_rdat),
        .busy(f_busy), .gnt(f_gnt)
    );

    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | {25'd0, a};
    endfunction

    // Register file behind the bus: returns stored value + 0xFF
    logic [DW-1:0] bus_mem [128];
    logic [127:0]  bus_wr = '0;
    always @(posedge clk) begin
        if (we) begin
            bus_mem[addr] <= wdat;
            bus_wr[addr]  <= 1'b1;
        end
    end
    assign rdat   = (bus_wr[addr] ? bus_mem[addr] : seed(addr)) + 32'h0000_00FF;
    assign f_rdat = seed(f_addr) + 32'h0000_00FF;

    // Reference register contents, updated per completed transaction
    logic [DW-1:0] mdl_mem [128];
    logic [127:0]  mdl_wr;

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        return (mdl_wr[a] ? mdl_mem[a] : seed(a)) + 32'h0000_00FF;
    endfunction

    task automatic mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mdl_mem[a] = d;
        mdl_wr[a]  = 1'b1;
    endtask

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic m, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!m) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdat = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdat = d;
        end
    endtask

    function automatic logic ack_of(input logic m);
        return m ? m1_ack : m0_ack;
    endfunction

    function automatic logic [DW-1:0] rdat_of(input logic m);
        return m ? m1_rdat : m0_rdat;
    endfunction

    typedef struct {
        logic          m;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        logic          scr;
    } vec_t;

    vec_t vt [9];

    // One isolated transaction: grant, strobe, 2-cycle ack latency, data.
    task automatic run_txn(input vec_t v);
        logic [DW-1:0] old_rd;
        logic [AW-1:0] seen_a;
        logic [DW-1:0] seen_d;
        int lat, strobes, other, acks;
        old_rd = rdat_of(v.m);
        seen_a = '0; seen_d = '0;
        lat = 0; strobes = 0; other = 0; acks = 0;
        drive(v.m, 1'b1, v.wr, v.a, v.d);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) begin
                chk("txn_gnt", gnt, v.m);
                chk("txn_busy", busy, 1);
                if (v.scr) drive(v.m, 1'b1, ~v.wr, ~v.a, ~v.d);
            end
            if (we) begin
                strobes++;
                seen_a = addr;
                seen_d = wdat;
            end
            if (ack_of(!v.m)) other++;
            if (ack_of(v.m)) begin
                acks++;
                if (lat == 0) begin
                    lat = i;
                    chk("txn_rdat", rdat_of(v.m), v.wr ? old_rd : v.exp_rd);
                    drive(v.m, 1'b0, v.wr, v.a, v.d);
                end
            end
        end
        chk("txn_ack_latency", lat, 2);
        chk("txn_ack_count", acks, 1);
        chk("txn_other_ack", other, 0);
        chk("txn_strobes", strobes, v.wr ? 1 : 0);
        if (v.wr) begin
            chk("txn_bus_addr", seen_a, v.a);
            chk("txn_bus_wdat", seen_d, v.d);
            mdl_write(v.a, v.d);
        end
        chk("txn_idle_busy", busy, 0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [4];
        int n, ov, wide, t_last0, t1;
        logic p0, p1;
        logic c_req [2];
        logic c_we  [2];
        logic [AW-1:0] c_a [2];
        logic [DW-1:0] c_d [2];
        int cool [2];
        int ack_at [2];
        logic pend_rd [2];
        logic [DW-1:0] pend_val [2];
        logic [DW-1:0] hold [2];
        logic mg, w, exp_we, ea0, ea1;
        logic [AW-1:0] ex_a;
        logic [DW-1:0] ex_d;
        int mfree, e;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        f_m0_req = 1'b0;
        f_m1_req = 1'b0;
        mdl_wr = '0;

        vt[0] = '{m:1'b0, wr:1'b1, a:7'h7F, d:32'h1234_5678, exp_rd:32'h0,         scr:1'b0};
        vt[1] = '{m:1'b0, wr:1'b1, a:7'h0F, d:32'h1234_5678, exp_rd:32'h0,         scr:1'b0};
        vt[2] = '{m:1'b1, wr:1'b0, a:7'h0F, d:32'h0,         exp_rd:32'h1234_5777, scr:1'b0};
        vt[3] = '{m:1'b1, wr:1'b1, a:7'h01, d:32'hDEAD_BEEF, exp_rd:32'h0,         scr:1'b0};
        vt[4] = '{m:1'b0, wr:1'b0, a:7'h01, d:32'h0,         exp_rd:32'hDEAD_BFEE, scr:1'b1};
        vt[5] = '{m:1'b1, wr:1'b0, a:7'h7F, d:32'h0,         exp_rd:32'h1234_5777, scr:1'b0};
        vt[6] = '{m:1'b0, wr:1'b0, a:7'h00, d:32'h0,         exp_rd:32'hA5A5_00FF, scr:1'b0};
        vt[7] = '{m:1'b1, wr:1'b1, a:7'h7F, d:32'hCAFE_F00D, exp_rd:32'h0,         scr:1'b1};
        vt[8] = '{m:1'b0, wr:1'b0, a:7'h7F, d:32'h0,         exp_rd:32'hCAFE_F10C, scr:1'b0};

        // Reset held with a pending request: nothing may happen
        drive(1'b0, 1'b1, vt[0].wr, vt[0].a, vt[0].d);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_we", we, 0);
            chk("rst_ack0", m0_ack, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gnt", gnt, 1);
        end
        chk("rst_rdat0", m0_rdat, 0);
        chk("rst_rdat1", m1_rdat, 0);
        chk("rst_addr", addr, 0);
        chk("rst_fp_gnt", f_gnt, 1);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) run_txn(vt[i]);

        // Abort a write during ACCESS
        drive(1'b0, 1'b1, 1'b1, 7'h22, 32'h0BAD_F00D);
        tick();
        chk("abort_strobe", we, 1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 7'h22, 32'h0BAD_F00D);
        tick();
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack0", m0_ack, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("abort_no_ack0", m0_ack, 0);
        chk("abort_no_ack1", m1_ack, 0);
        mdl_write(7'h22, 32'h0BAD_F00D);
        run_txn('{m:1'b1, wr:1'b0, a:7'h22, d:32'h0, exp_rd:32'h0BAD_F10C, scr:1'b0});

        // Round-robin contention after reset: 0,1,0,1
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 7'h10, '0);
        drive(1'b1, 1'b1, 1'b0, 7'h11, '0);
        n = 0; ov = 0; wide = 0; p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (m0_ack && m1_ack) ov++;
            if ((m0_ack && p0) || (m1_ack && p1)) wide++;
            p0 = m0_ack;
            p1 = m1_ack;
            if (m0_ack) begin ord[n] = 0; n++; end
            if (m1_ack && n < 4) begin ord[n] = 1; n++; end
            m0_req = !m0_ack;
            m1_req = !m1_ack;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rr_count", n, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", (i < n) ? ord[i] : -1, i % 2);
        chk("rr_overlap", ov, 0);
        chk("rr_ack_width", wide, 0);
        for (int i = 0; i < 6; i++) tick();

        // Fixed priority: master 0 twice, master 1 only after 0 drops
        f_m0_req = 1'b1;
        f_m1_req = 1'b1;
        n = 0; ov = 0; t_last0 = 0; t1 = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            tick();
            if (f_m0_ack && f_m1_ack) ov++;
            if (f_m0_ack) begin ord[n] = 0; n++; t_last0 = cyc; end
            if (f_m1_ack && n < 3) begin ord[n] = 1; n++; t1 = cyc; end
            if (f_m0_ack) f_m0_req = 1'b0;
            else if (!f_m0_req && n < 2) f_m0_req = 1'b1;
            if (f_m1_ack) f_m1_req = 1'b0;
        end
        f_m0_req = 1'b0;
        f_m1_req = 1'b0;
        chk("fp_count", n, 3);
        chk("fp_order0", (n > 0) ? ord[0] : -1, 0);
        chk("fp_order1", (n > 1) ? ord[1] : -1, 0);
        chk("fp_order2", (n > 2) ? ord[2] : -1, 1);
        chk("fp_m1_gap", t1 - t_last0, 3);
        chk("fp_overlap", ov, 0);

        // Randomized run against the transaction-level model
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mg = 1'b1; mfree = 0;
        for (int m = 0; m < 2; m++) begin
            c_req[m] = 1'b0; c_we[m] = 1'b0; c_a[m] = '0; c_d[m] = '0;
            cool[m] = 0; ack_at[m] = -10; pend_rd[m] = 1'b0;
            pend_val[m] = '0; hold[m] = '0;
        end
        ex_a = '0; ex_d = '0;
        for (int i = 0; i < 820; i++) begin
            e = cyc + 1;
            exp_we = 1'b0;
            if (e >= mfree && (c_req[0] || c_req[1])) begin
                w = (c_req[0] && c_req[1]) ? ~mg : c_req[1];
                mg = w;
                mfree = e + 3;
                ack_at[w] = e + 1;
                exp_we = c_we[w];
                ex_a = c_a[w];
                ex_d = c_d[w];
                pend_rd[w] = !c_we[w];
                if (c_we[w]) mdl_write(c_a[w], c_d[w]);
                else pend_val[w] = mdl_read(c_a[w]);
            end
            tick();
            ea0 = (ack_at[0] == e);
            ea1 = (ack_at[1] == e);
            if (ea0 && pend_rd[0]) hold[0] = pend_val[0];
            if (ea1 && pend_rd[1]) hold[1] = pend_val[1];
            chk("rnd_ack0", m0_ack, ea0);
            chk("rnd_ack1", m1_ack, ea1);
            chk("rnd_we", we, exp_we);
            if (exp_we) begin
                chk("rnd_addr", addr, ex_a);
                chk("rnd_wdat", wdat, ex_d);
            end
            chk("rnd_busy", busy, (e + 1) < mfree);
            chk("rnd_gnt", gnt, mg);
            chk("rnd_rdat0", m0_rdat, hold[0]);
            chk("rnd_rdat1", m1_rdat, hold[1]);
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? ea0 : ea1) begin
                    c_req[m] = 1'b0;
                    cool[m] = $urandom_range(1, 3);
                end else if (!c_req[m]) begin
                    if (cool[m] > 0) cool[m]--;
                    else if (i < 800 && $urandom_range(0, 2) == 0) begin
                        c_req[m] = 1'b1;
                        c_we[m]  = 1'($urandom_range(0, 1));
                        c_a[m]   = 7'($urandom_range(0, 15));
                        c_d[m]   = $urandom;
                    end
                end
                drive(1'(m), c_req[m], c_we[m], c_a[m], c_d[m]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Two-master arbiter for the shared register bus (we / addr / wdat / rdat).
- Master 0 is the UART command parser; master 1 is any on-chip sequencer, e.g. a DDS sweep engine.
- Serialises single-word read/write transactions using a req/ack handshake.
- Round-robin or fixed-priority grant; exactly one bus access in flight.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 32, register data width.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- m0_req  input  1  master 0 transaction request, held until m0_ack
- m0_we  input  1  master 0: 1 = write, 0 = read
- m0_addr  input  ADDR_W  master 0 register address
- m0_wdat  input  DATA_W  master 0 write data
- m0_ack  output  1  master 0 one-cycle completion pulse
- m0_rdat  output  DATA_W  master 0 read data, valid while m0_ack=1 and held afterwards
- m1_req, m1_we, m1_addr, m1_wdat, m1_ack, m1_rdat  same as master 0, for master 1
- we  output  1  register bus write strobe
- addr  output  ADDR_W  register bus address
- wdat  output  DATA_W  register bus write data
- rdat  input  DATA_W  register bus read data, combinational from addr
- busy  output  1  1 whenever state != IDLE
- gnt  output  1  index of the current or last granted master

Behaviour:
- Reset (clk edge with rst=0):
  - state=IDLE; we=0; addr=0; wdat=0.
  - m0_ack=m1_ack=0; m0_rdat=m1_rdat=0.
  - gnt=1, so master 0 wins the first tie in round-robin mode.
  - busy=0.
  - A reset mid-transaction aborts it: no ack, no write strobe after the reset edge.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay in IDLE; we=0.
  - One req: grant that master.
  - Both req, FIXED_PRIO=1: grant master 0.
  - Both req, FIXED_PRIO=0: grant the master opposite to gnt.
  - On grant, at the same edge: gnt <= winner; latch winner's we/addr/wdat into the bus registers addr/wdat and an internal we_l; state -> ACCESS.
- ACCESS (exactly 1 cycle):
  - addr/wdat stable; we = we_l, i.e. a registered one-cycle strobe for writes, 0 for reads.
  - At the end edge: if read, capture rdat into mX_rdat of the granted master; we <= 0; state -> ACK.
- ACK (exactly 1 cycle):
  - ack of the granted master = 1; the other ack = 0; state -> IDLE.
- Latency:
  - req sampled high at edge k -> ACCESS cycle k..k+1 -> ack high k+1..k+2.
  - 2 cycles from request sample to ack; 3 cycles per transaction minimum.
- Handshake rules:
  - A master must hold req and its command fields stable until it sees ack, then drop req at the next edge.
  - The IDLE cycle after ACK guarantees the dropped req is not re-granted.
  - Changing fields after the grant edge has no effect, because they are latched.
  - req dropped before ack: the transaction still completes and ack still pulses.
- Write transactions: mX_rdat is not updated. addr/wdat hold their last values in IDLE.
- Round-robin fairness: with both masters requesting continuously, grants alternate 0,1,0,1…
- The non-granted master's request stays pending without loss.
- acks are mutually exclusive and never asserted outside ACK.

Test Plan:
- Reset: hold rst=0 for 3 cycles with m0_req=1 -> no we, no ack, busy=0, gnt=1. Release -> master 0 granted first.
- M0 write: addr=0x7F, wdat=0x1234_5678 -> we=1 for exactly one cycle with addr=0x7F, wdat=0x12345678. m0_ack pulses 2 cycles after request sample. m1_ack stays 0.
- M1 read: addr=0x0F, bench returns rdat=stored+0xFF, e.g. 0x12345777 -> m1_rdat=0x12345777 when m1_ack=1. we stays 0 throughout.
- Contention, FIXED_PRIO=0: both req continuously for 4 transactions -> grant order 0,1,0,1. Each ack is one cycle long and they never overlap.
- Contention, FIXED_PRIO=1: both req -> master 0 always granted first. Master 1 granted only in the IDLE cycle after master 0 drops req.
- Abort: assert rst=0 during ACCESS of a write -> we deasserts at the reset edge, no ack issued, next transaction proceeds normally after release.
